// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   // Value every register and dump holding register takes on reset.
   localparam int unsigned RST_VAL = 0;

   typedef enum logic {
      DUMP_IDLE = 1'b0,
      DUMP_SCAN = 1'b1
   } dumpState_t;

endpackage

// File: rtl/regfile_if.sv
// Register file bus: write port, two read ports, scoreboard and dump handshake.
interface regfile_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   localparam int AW = $clog2(NREG);

   logic            iWE;
   logic [AW-1:0]   iRD;
   logic [XLEN-1:0] iREG_IN;
   logic [AW-1:0]   iRS1;
   logic [AW-1:0]   iRS2;
   logic [XLEN-1:0] oREG_OUT1;
   logic [XLEN-1:0] oREG_OUT2;
   logic            iSB_SET;
   logic [AW-1:0]   iSB_IDX;
   logic            oRS1_BUSY;
   logic            oRS2_BUSY;
   logic            iDUMP_REQ;
   logic            oDUMP_BUSY;
   logic            oDUMP_VALID;
   logic            iDUMP_READY;
   logic [AW-1:0]   oDUMP_IDX;
   logic [XLEN-1:0] oDUMP_DATA;
   logic            oDUMP_LAST;

   modport master (
      output iWE, iRD, iREG_IN, iRS1, iRS2, iSB_SET, iSB_IDX, iDUMP_REQ, iDUMP_READY,
      input  oREG_OUT1, oREG_OUT2, oRS1_BUSY, oRS2_BUSY,
      input  oDUMP_BUSY, oDUMP_VALID, oDUMP_IDX, oDUMP_DATA, oDUMP_LAST
   );

   modport slave (
      input  iWE, iRD, iREG_IN, iRS1, iRS2, iSB_SET, iSB_IDX, iDUMP_REQ, iDUMP_READY,
      output oREG_OUT1, oREG_OUT2, oRS1_BUSY, oRS2_BUSY,
      output oDUMP_BUSY, oDUMP_VALID, oDUMP_IDX, oDUMP_DATA, oDUMP_LAST
   );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Serial readout of every register, one entry per accepted handshake.
// An entry's data is captured when it is loaded and held until accepted.
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iReq,
   input  logic            iReady,
   output logic [AW-1:0]   oRdIdx,
   input  logic [XLEN-1:0] iRdData,
   output logic            oBusy,
   output logic            oValid,
   output logic [AW-1:0]   oIdx,
   output logic [XLEN-1:0] oData,
   output logic            oLast
);

   dumpState_t      stateQ, stateNext;
   logic [AW-1:0]   idxQ;
   logic [XLEN-1:0] dataQ;
   logic            load;
   logic            finish;
   logic [AW-1:0]   loadIdx;
   logic            atLast;

   assign atLast = (idxQ == AW'(NREG - 1));

   // Next state plus which entry (if any) gets loaded at this edge.
   always_comb begin
      stateNext = stateQ;
      load      = 1'b0;
      finish    = 1'b0;
      loadIdx   = '0;
      case (stateQ)
         DUMP_IDLE: begin
            if (iReq) begin
               stateNext = DUMP_SCAN;
               load      = 1'b1;
            end
         end
         DUMP_SCAN: begin
            if (iReady) begin
               if (atLast) begin
                  stateNext = DUMP_IDLE;
                  finish    = 1'b1;
               end else begin
                  load    = 1'b1;
                  loadIdx = idxQ + AW'(1);
               end
            end
         end
         default: stateNext = DUMP_IDLE;
      endcase
   end

   // Bypassed storage read of the entry about to be loaded.
   assign oRdIdx = loadIdx;

   // State, index and held data; cleared on reset and at scan end.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         stateQ <= DUMP_IDLE;
         idxQ   <= '0;
         dataQ  <= XLEN'(RST_VAL);
      end else begin
         stateQ <= stateNext;
         if (load) begin
            idxQ  <= loadIdx;
            dataQ <= iRdData;
         end else if (finish) begin
            idxQ  <= '0;
            dataQ <= XLEN'(RST_VAL);
         end
      end
   end

   assign oBusy  = (stateQ == DUMP_SCAN);
   assign oValid = (stateQ == DUMP_SCAN);
   assign oIdx   = idxQ;
   assign oData  = dataQ;
   assign oLast  = oValid && atLast;

endmodule

// File: rtl/regfile_param.sv
// Integer register file: storage, write-bypassed read ports, pending-write
// scoreboard, and the dump readout engine.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input logic     iCLK,
   input logic     iRST,
   regfile_if.slave bus
);

   localparam int NPORT = 3; // rs1, rs2, dump

   logic [XLEN-1:0]             regs [NREG];
   logic [NREG-1:0]             sb;
   logic [NPORT-1:0][AW-1:0]    rdIdx;
   logic [NPORT-1:0][XLEN-1:0]  rdData;
   logic [NPORT-1:0]            wrHit;
   logic [AW-1:0]               dumpRdIdx;
   logic                        wrDrop;
   logic                        setDrop;

   assign wrDrop  = (ZERO_REG != 0) && (bus.iRD == '0);
   assign setDrop = (ZERO_REG != 0) && (bus.iSB_IDX == '0);
   assign rdIdx   = {dumpRdIdx, bus.iRS2, bus.iRS1};

   // Storage write; register 0 stays zero when hardwired.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < NREG; i++) regs[i] <= XLEN'(RST_VAL);
      end else if (bus.iWE && !wrDrop) begin
         regs[bus.iRD] <= bus.iREG_IN;
      end
   end

   // Scoreboard: a write clears, a set marks; set is applied last so it wins.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sb <= '0;
      end else begin
         if (bus.iWE) sb[bus.iRD] <= 1'b0;
         if (bus.iSB_SET && !setDrop) sb[bus.iSB_IDX] <= 1'b1;
      end
   end

   // Every read port sees a same-cycle write to its index.
   for (genvar p = 0; p < NPORT; p++) begin : g_rd
      assign wrHit[p]  = bus.iWE && (bus.iRD == rdIdx[p]);
      assign rdData[p] = (wrHit[p] && !((ZERO_REG != 0) && (rdIdx[p] == '0)))
                         ? bus.iREG_IN : regs[rdIdx[p]];
   end

   assign bus.oREG_OUT1 = rdData[0];
   assign bus.oREG_OUT2 = rdData[1];
   assign bus.oRS1_BUSY = sb[rdIdx[0]] && !wrHit[0];
   assign bus.oRS2_BUSY = sb[rdIdx[1]] && !wrHit[1];

   regfile_dump_fsm #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) uDump (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iReq    (bus.iDUMP_REQ),
      .iReady  (bus.iDUMP_READY),
      .oRdIdx  (dumpRdIdx),
      .iRdData (rdData[2]),
      .oBusy   (bus.oDUMP_BUSY),
      .oValid  (bus.oDUMP_VALID),
      .oIdx    (bus.oDUMP_IDX),
      .oData   (bus.oDUMP_DATA),
      .oLast   (bus.oDUMP_LAST)
   );

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param with a behavioural array model.
module tb_regfile_param;

   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nTests = 0;
   int   nFail  = 0;

   logic [XLEN-1:0] mem [NREG];
   bit              sbm [NREG];

   regfile_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   regfile_param #(.XLEN(XLEN), .NREG(NREG), .ZERO_REG(1)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.iWE = 1'b0; bus.iRD = '0; bus.iREG_IN = '0;
      bus.iRS1 = '0; bus.iRS2 = '0;
      bus.iSB_SET = 1'b0; bus.iSB_IDX = '0;
      bus.iDUMP_REQ = 1'b0; bus.iDUMP_READY = 1'b0;
   endtask

   // Commit the model for the inputs currently driven, then cross an edge.
   task automatic tick();
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin mem[i] = '0; sbm[i] = 1'b0; end
      end else begin
         if (bus.iWE) begin
            if (bus.iRD != 0) mem[bus.iRD] = bus.iREG_IN;
            sbm[bus.iRD] = 1'b0;
         end
         if (bus.iSB_SET && bus.iSB_IDX != 0) sbm[bus.iSB_IDX] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input int idx);
      if (bus.iWE && int'(bus.iRD) == idx && idx != 0) return bus.iREG_IN;
      return mem[idx];
   endfunction

   function automatic logic exp_busy(input int idx);
      return sbm[idx] && !(bus.iWE && int'(bus.iRD) == idx);
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      bus.iWE = 1'b1; bus.iRD = 5; bus.iREG_IN = 32'hFFFF; bus.iSB_SET = 1'b1; bus.iSB_IDX = 5;
      tick();
      rst = 1'b0;
      idle_inputs();
      bus.iRS1 = 5; bus.iRS2 = 9;
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'h0) begin nFail++; $display("FAIL reset_out1: got %h want 0", bus.oREG_OUT1); end
      nTests++; if (bus.oRS1_BUSY !== 1'b0) begin nFail++; $display("FAIL reset_busy1: got %b want 0", bus.oRS1_BUSY); end
      nTests++; if (bus.oREG_OUT2 !== 32'h0) begin nFail++; $display("FAIL reset_out2: got %h want 0", bus.oREG_OUT2); end
      nTests++; if ({bus.oDUMP_BUSY, bus.oDUMP_VALID, bus.oDUMP_LAST} !== 3'b000) begin nFail++; $display("FAIL reset_dump_flags: got %b want 000", {bus.oDUMP_BUSY, bus.oDUMP_VALID, bus.oDUMP_LAST}); end
      nTests++; if (bus.oDUMP_IDX !== 5'd0 || bus.oDUMP_DATA !== 32'h0) begin nFail++; $display("FAIL reset_dump_idx_data: got %0d/%h want 0/0", bus.oDUMP_IDX, bus.oDUMP_DATA); end
   endtask

   task automatic test_bypass();
      idle_inputs();
      bus.iWE = 1'b1; bus.iRD = 5; bus.iREG_IN = 32'hDEADBEEF; bus.iRS1 = 5;
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'hDEADBEEF) begin nFail++; $display("FAIL bypass_same_cycle: got %h want deadbeef", bus.oREG_OUT1); end
      tick();
      bus.iWE = 1'b0;
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'hDEADBEEF) begin nFail++; $display("FAIL bypass_stored: got %h want deadbeef", bus.oREG_OUT1); end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      bus.iWE = 1'b1; bus.iRD = 0; bus.iREG_IN = 32'h1234; bus.iSB_SET = 1'b1; bus.iSB_IDX = 0; bus.iRS1 = 0;
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'h0) begin nFail++; $display("FAIL zero_same_cycle: got %h want 0", bus.oREG_OUT1); end
      tick();
      idle_inputs();
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'h0) begin nFail++; $display("FAIL zero_stored: got %h want 0", bus.oREG_OUT1); end
      nTests++; if (bus.oRS1_BUSY !== 1'b0) begin nFail++; $display("FAIL zero_busy: got %b want 0", bus.oRS1_BUSY); end
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      bus.iSB_SET = 1'b1; bus.iSB_IDX = 7; bus.iRS1 = 7; bus.iRS2 = 7;
      #1;
      nTests++; if (bus.oRS1_BUSY !== 1'b0) begin nFail++; $display("FAIL sb_before_set: got %b want 0", bus.oRS1_BUSY); end
      tick();
      bus.iSB_SET = 1'b0;
      #1;
      nTests++; if (bus.oRS1_BUSY !== 1'b1) begin nFail++; $display("FAIL sb_after_set: got %b want 1", bus.oRS1_BUSY); end
      tick();
      nTests++; if (bus.oRS2_BUSY !== 1'b1) begin nFail++; $display("FAIL sb_held_rs2: got %b want 1", bus.oRS2_BUSY); end
      bus.iWE = 1'b1; bus.iRD = 7; bus.iREG_IN = 32'h77;
      #1;
      nTests++; if (bus.oRS1_BUSY !== 1'b0) begin nFail++; $display("FAIL sb_write_bypass: got %b want 0", bus.oRS1_BUSY); end
      tick();
      bus.iWE = 1'b0;
      #1;
      nTests++; if (bus.oRS1_BUSY !== 1'b0) begin nFail++; $display("FAIL sb_cleared: got %b want 0", bus.oRS1_BUSY); end
      bus.iWE = 1'b1; bus.iRD = 7; bus.iREG_IN = 32'h78; bus.iSB_SET = 1'b1; bus.iSB_IDX = 7;
      tick();
      idle_inputs();
      bus.iRS1 = 7;
      #1;
      nTests++; if (bus.oRS1_BUSY !== 1'b1) begin nFail++; $display("FAIL sb_set_wins: got %b want 1", bus.oRS1_BUSY); end
      nTests++; if (bus.oREG_OUT1 !== 32'h78) begin nFail++; $display("FAIL sb_set_wins_data: got %h want 78", bus.oREG_OUT1); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         idle_inputs();
         bus.iWE     = 1'($urandom_range(0, 1));
         bus.iRD     = 5'($urandom_range(0, NREG - 1));
         bus.iREG_IN = $urandom;
         bus.iRS1    = ($urandom_range(0, 3) == 0) ? bus.iRD : 5'($urandom_range(0, NREG - 1));
         bus.iRS2    = ($urandom_range(0, 3) == 0) ? bus.iRD : 5'($urandom_range(0, NREG - 1));
         bus.iSB_SET = 1'($urandom_range(0, 1));
         bus.iSB_IDX = ($urandom_range(0, 3) == 0) ? bus.iRD : 5'($urandom_range(0, NREG - 1));
         #1;
         nTests++; if (bus.oREG_OUT1 !== exp_rd(int'(bus.iRS1))) begin nFail++; $display("FAIL rand_out1 rs=%0d: got %h want %h", bus.iRS1, bus.oREG_OUT1, exp_rd(int'(bus.iRS1))); end
         nTests++; if (bus.oREG_OUT2 !== exp_rd(int'(bus.iRS2))) begin nFail++; $display("FAIL rand_out2 rs=%0d: got %h want %h", bus.iRS2, bus.oREG_OUT2, exp_rd(int'(bus.iRS2))); end
         nTests++; if (bus.oRS1_BUSY !== exp_busy(int'(bus.iRS1))) begin nFail++; $display("FAIL rand_busy1 rs=%0d: got %b want %b", bus.iRS1, bus.oRS1_BUSY, exp_busy(int'(bus.iRS1))); end
         nTests++; if (bus.oRS2_BUSY !== exp_busy(int'(bus.iRS2))) begin nFail++; $display("FAIL rand_busy2 rs=%0d: got %b want %b", bus.iRS2, bus.oRS2_BUSY, exp_busy(int'(bus.iRS2))); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_dump_full();
      idle_inputs();
      for (int i = 0; i < NREG; i++) begin
         bus.iWE = 1'b1; bus.iRD = 5'(i); bus.iREG_IN = 32'(i * 'h11);
         tick();
      end
      idle_inputs();
      bus.iDUMP_READY = 1'b1; bus.iDUMP_REQ = 1'b1;
      #1;
      nTests++; if (bus.oDUMP_VALID !== 1'b0) begin nFail++; $display("FAIL dump_req_cycle_valid: got %b want 0", bus.oDUMP_VALID); end
      tick();
      bus.iDUMP_REQ = 1'b0;
      for (int k = 0; k < NREG; k++) begin
         nTests++;
         if (bus.oDUMP_VALID !== 1'b1 || bus.oDUMP_BUSY !== 1'b1 || bus.oDUMP_IDX !== 5'(k) ||
             bus.oDUMP_DATA !== 32'(k * 'h11) || bus.oDUMP_LAST !== (k == NREG - 1)) begin
            nFail++;
            $display("FAIL dump_full_entry%0d: got v=%b b=%b idx=%0d data=%h last=%b want v=1 b=1 idx=%0d data=%h last=%b",
                     k, bus.oDUMP_VALID, bus.oDUMP_BUSY, bus.oDUMP_IDX, bus.oDUMP_DATA, bus.oDUMP_LAST,
                     k, 32'(k * 'h11), (k == NREG - 1));
         end
         tick();
      end
      nTests++; if (bus.oDUMP_BUSY !== 1'b0 || bus.oDUMP_VALID !== 1'b0) begin nFail++; $display("FAIL dump_full_end: got b=%b v=%b want 0 0", bus.oDUMP_BUSY, bus.oDUMP_VALID); end
      idle_inputs();
   endtask

   task automatic test_dump_stall();
      int n;
      idle_inputs();
      bus.iDUMP_READY = 1'b1; bus.iDUMP_REQ = 1'b1;
      tick();
      bus.iDUMP_REQ = 1'b0;
      for (int k = 0; k < 3; k++) begin
         nTests++; if (bus.oDUMP_IDX !== 5'(k)) begin nFail++; $display("FAIL stall_pre_idx: got %0d want %0d", bus.oDUMP_IDX, k); end
         tick();
      end
      bus.iDUMP_READY = 1'b0;
      for (int s = 0; s < 5; s++) begin
         bus.iWE = (s == 0); bus.iRD = 3; bus.iREG_IN = 32'hFF; bus.iDUMP_REQ = (s == 0);
         #1;
         nTests++;
         if (bus.oDUMP_VALID !== 1'b1 || bus.oDUMP_IDX !== 5'd3 || bus.oDUMP_DATA !== 32'h33) begin
            nFail++;
            $display("FAIL stall_hold s=%0d: got v=%b idx=%0d data=%h want v=1 idx=3 data=33", s, bus.oDUMP_VALID, bus.oDUMP_IDX, bus.oDUMP_DATA);
         end
         tick();
      end
      idle_inputs();
      bus.iRS1 = 3;
      #1;
      nTests++; if (bus.oREG_OUT1 !== 32'hFF) begin nFail++; $display("FAIL stall_reg_written: got %h want ff", bus.oREG_OUT1); end
      nTests++; if (bus.oDUMP_DATA !== 32'h33) begin nFail++; $display("FAIL stall_data_kept: got %h want 33", bus.oDUMP_DATA); end
      bus.iDUMP_READY = 1'b1;
      tick();
      nTests++; if (bus.oDUMP_IDX !== 5'd4 || bus.oDUMP_DATA !== 32'h44) begin nFail++; $display("FAIL stall_next_entry: got idx=%0d data=%h want 4/44", bus.oDUMP_IDX, bus.oDUMP_DATA); end
      // Write x5 in the very cycle entry 5 is loaded: capture must see it.
      bus.iWE = 1'b1; bus.iRD = 5; bus.iREG_IN = 32'h5A5A;
      tick();
      bus.iWE = 1'b0;
      nTests++; if (bus.oDUMP_IDX !== 5'd5 || bus.oDUMP_DATA !== 32'h5A5A) begin nFail++; $display("FAIL capture_bypass: got idx=%0d data=%h want 5/5a5a", bus.oDUMP_IDX, bus.oDUMP_DATA); end
      n = 0;
      while (bus.oDUMP_BUSY && n < 40) begin tick(); n++; end
      nTests++; if (bus.oDUMP_BUSY !== 1'b0) begin nFail++; $display("FAIL stall_drain_timeout: got busy=%b want 0", bus.oDUMP_BUSY); end
      tick();
      nTests++; if (bus.oDUMP_BUSY !== 1'b0 || bus.oDUMP_VALID !== 1'b0) begin nFail++; $display("FAIL req_not_queued: got b=%b v=%b want 0 0", bus.oDUMP_BUSY, bus.oDUMP_VALID); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_scan();
      int n;
      idle_inputs();
      bus.iDUMP_READY = 1'b1; bus.iDUMP_REQ = 1'b1;
      tick();
      bus.iDUMP_REQ = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      nTests++; if (bus.oDUMP_IDX !== 5'd10 || bus.oDUMP_DATA !== 32'hAA) begin nFail++; $display("FAIL midscan_idx: got idx=%0d data=%h want 10/aa", bus.oDUMP_IDX, bus.oDUMP_DATA); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.iDUMP_READY = 1'b0;
      #1;
      nTests++;
      if ({bus.oDUMP_BUSY, bus.oDUMP_VALID, bus.oDUMP_LAST} !== 3'b000 || bus.oDUMP_IDX !== 5'd0 || bus.oDUMP_DATA !== 32'h0) begin
         nFail++;
         $display("FAIL midscan_reset_dump: got b=%b v=%b l=%b idx=%0d data=%h want all 0",
                  bus.oDUMP_BUSY, bus.oDUMP_VALID, bus.oDUMP_LAST, bus.oDUMP_IDX, bus.oDUMP_DATA);
      end
      for (int i = 0; i < NREG; i++) begin
         bus.iRS1 = 5'(i); bus.iRS2 = 5'(NREG - 1 - i);
         #1;
         nTests++; if (bus.oREG_OUT1 !== 32'h0 || bus.oREG_OUT2 !== 32'h0) begin nFail++; $display("FAIL midscan_regs_clear x%0d: got %h/%h want 0/0", i, bus.oREG_OUT1, bus.oREG_OUT2); end
      end
      bus.iDUMP_REQ = 1'b1;
      tick();
      bus.iDUMP_REQ = 1'b0;
      nTests++; if (bus.oDUMP_VALID !== 1'b1 || bus.oDUMP_IDX !== 5'd0 || bus.oDUMP_DATA !== 32'h0) begin nFail++; $display("FAIL midscan_restart: got v=%b idx=%0d data=%h want 1/0/0", bus.oDUMP_VALID, bus.oDUMP_IDX, bus.oDUMP_DATA); end
      bus.iDUMP_READY = 1'b1;
      n = 0;
      while (bus.oDUMP_BUSY && n < 40) begin tick(); n++; end
      nTests++; if (bus.oDUMP_BUSY !== 1'b0) begin nFail++; $display("FAIL restart_drain_timeout: got busy=%b want 0", bus.oDUMP_BUSY); end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_random();
      test_dump_full();
      test_dump_stall();
      test_reset_mid_scan();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
